// File: rtl/otp_seq_pkg.sv
// Shared constants for the OTP input sequencer.
// State encoding, digit count and default timing values.
package otp_seq_pkg;

   localparam int DIGITS       = 4;
   localparam int DEF_DEBOUNCE = 500_000;
   localparam int DEF_SETTLE   = 16;
   localparam int DEF_CHECK    = 4;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SPIN    = 3'd1;
   localparam logic [2:0] S_ISSUE   = 3'd2;
   localparam logic [2:0] S_COLLECT = 3'd3;
   localparam logic [2:0] S_CHECK   = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;
   localparam logic [2:0] S_LOCK    = 3'd6;

   // Busy everywhere except waiting for a session or for digits.
   function automatic logic state_busy(input logic [2:0] s);
      return !((s == S_IDLE) || (s == S_COLLECT));
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counter debouncer and rising-edge pulse.
// press_o is one cycle wide on the cycle the debounced level rises.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic press_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                       $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q;
   logic          s2_q;
   logic          lvl_q;
   logic          lvl_d;
   logic          press_q;
   logic          press_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Level flips on the Nth consecutive disagreeing sample.
   always_comb begin
      lvl_d   = lvl_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (s2_q != lvl_q) begin
         if (cnt_q == CNT_LAST) begin
            lvl_d   = s2_q;
            press_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchronizer and debounce state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         lvl_q   <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= raw_i;
         s2_q    <= s1_q;
         lvl_q   <= lvl_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/otp_input_sequencer.sv
// Front-end sequencer feeding the OTP checker: LFSR spin, capture, digits.
// Optional GEN_BUTTON_EN: session start waits for a debounced generate press.
module otp_input_sequencer
   import otp_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
   parameter int LFSR_SETTLE     = DEF_SETTLE,
   parameter int CHECK_CYCLES    = DEF_CHECK
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_enter_raw,
   input  logic        btn_gen_raw,
   input  logic [3:0]  sw_digit_raw,
   input  logic [15:0] lfsr_value,
   input  logic        unlock,
   input  logic        reset_sys,
   input  logic        expired,
   output logic        lfsr_step,
   output logic [15:0] lfsr_digit,
   output logic        lfsr_latch,
   output logic [3:0]  user_digit,
   output logic        user_latch,
   output logic [2:0]  digit_count,
   output logic        lockout,
   output logic        busy
);

   localparam int SW = $clog2(LFSR_SETTLE + 1);
   localparam int KW = $clog2(CHECK_CYCLES + 1);
   localparam logic [SW-1:0] SPIN_LAST = SW'(LFSR_SETTLE - 1);
   localparam logic [KW-1:0] CHK_LAST  = KW'(CHECK_CYCLES - 1);
   localparam logic [2:0]    CNT_LAST  = 3'(DIGITS - 1);

   logic          enter_press;
   logic          gen_press;
   logic [3:0]    sw_s1_q;
   logic [3:0]    sw_s2_q;

   logic [2:0]    state_q;
   logic [2:0]    state_d;
   logic [SW-1:0] spin_q;
   logic [SW-1:0] spin_d;
   logic [KW-1:0] chk_q;
   logic [KW-1:0] chk_d;
   logic [15:0]   otp_q;
   logic [15:0]   otp_d;
   logic [3:0]    udig_q;
   logic [3:0]    udig_d;
   logic          ulatch_q;
   logic          ulatch_d;
   logic [2:0]    cnt_q;
   logic [2:0]    cnt_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_enter (
      .clk    (clk),
      .rst_n  (reset),
      .raw_i  (btn_enter_raw),
      .press_o(enter_press)
   );

`ifdef GEN_BUTTON_EN
   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_gen (
      .clk    (clk),
      .rst_n  (reset),
      .raw_i  (btn_gen_raw),
      .press_o(gen_press)
   );
`else
   logic unused_gen;
   assign unused_gen = btn_gen_raw;
   assign gen_press  = 1'b1;
`endif

   // Digit switches are only synchronized; the press picks the value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_s1_q <= 4'h0;
         sw_s2_q <= 4'h0;
      end else begin
         sw_s1_q <= sw_digit_raw;
         sw_s2_q <= sw_s1_q;
      end
   end

   // Session FSM: spin, capture, collect digits, then judge the attempt.
   always_comb begin
      state_d  = state_q;
      spin_d   = spin_q;
      chk_d    = chk_q;
      otp_d    = otp_q;
      udig_d   = udig_q;
      ulatch_d = 1'b0;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            spin_d = '0;
            if (gen_press) begin
               state_d = S_SPIN;
            end
         end
         S_SPIN: begin
            if (spin_q == SPIN_LAST) begin
               state_d = S_ISSUE;
               otp_d   = lfsr_value;
               cnt_d   = 3'd0;
            end else begin
               spin_d = spin_q + 1'b1;
            end
         end
         S_ISSUE: begin
            state_d = S_COLLECT;
         end
         S_COLLECT: begin
            if (expired) begin
               state_d = S_LOCK;
            end else if (enter_press) begin
               udig_d   = sw_s2_q;
               ulatch_d = 1'b1;
               cnt_d    = cnt_q + 3'd1;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_CHECK;
                  chk_d   = '0;
               end
            end
         end
         S_CHECK: begin
            if (expired) begin
               state_d = S_LOCK;
            end else if (chk_q == CHK_LAST) begin
               if (unlock) begin
                  state_d = S_DONE;
               end else if (reset_sys) begin
                  state_d = S_LOCK;
               end else begin
                  state_d = S_COLLECT;
                  cnt_d   = 3'd0;
               end
            end else begin
               chk_d = chk_q + 1'b1;
            end
         end
         S_DONE: begin
            if (!unlock) begin
               state_d = S_IDLE;
            end
         end
         S_LOCK: begin
            if (!reset_sys && !expired) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         spin_q   <= '0;
         chk_q    <= '0;
         otp_q    <= 16'h0000;
         udig_q   <= 4'h0;
         ulatch_q <= 1'b0;
         cnt_q    <= 3'd0;
      end else begin
         state_q  <= state_d;
         spin_q   <= spin_d;
         chk_q    <= chk_d;
         otp_q    <= otp_d;
         udig_q   <= udig_d;
         ulatch_q <= ulatch_d;
         cnt_q    <= cnt_d;
      end
   end

   assign lfsr_step   = (state_q == S_SPIN);
   assign lfsr_latch  = (state_q == S_ISSUE);
   assign lockout     = (state_q == S_LOCK);
   assign busy        = state_busy(state_q);
   assign lfsr_digit  = otp_q;
   assign user_digit  = udig_q;
   assign user_latch  = ulatch_q;
   assign digit_count = cnt_q;

endmodule

// File: tb/tb_otp_input_sequencer.sv
// Scoreboard bench for otp_input_sequencer.
// Expected latch events are queued; a monitor pops them on each strobe.
module tb_otp_input_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        btn_enter_raw;
   logic        btn_gen_raw;
   logic [3:0]  sw_digit_raw;
   logic [15:0] lfsr_value;
   logic        unlock;
   logic        reset_sys;
   logic        expired;
   logic        lfsr_step;
   logic [15:0] lfsr_digit;
   logic        lfsr_latch;
   logic [3:0]  user_digit;
   logic        user_latch;
   logic [2:0]  digit_count;
   logic        lockout;
   logic        busy;

   typedef struct packed {
      logic        is_user;
      logic [15:0] data;
      logic [2:0]  cnt;
   } ev_t;

   ev_t q[$];
   ev_t e;
   int  checks   = 0;
   int  failures = 0;
   int  exp_cnt  = 0;
   int  n;
   bit  seen;

   always #5 clk = ~clk;

   otp_input_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .LFSR_SETTLE    (3),
      .CHECK_CYCLES   (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_enter_raw(btn_enter_raw),
      .btn_gen_raw  (btn_gen_raw),
      .sw_digit_raw (sw_digit_raw),
      .lfsr_value   (lfsr_value),
      .unlock       (unlock),
      .reset_sys    (reset_sys),
      .expired      (expired),
      .lfsr_step    (lfsr_step),
      .lfsr_digit   (lfsr_digit),
      .lfsr_latch   (lfsr_latch),
      .user_digit   (user_digit),
      .user_latch   (user_latch),
      .digit_count  (digit_count),
      .lockout      (lockout),
      .busy         (busy)
   );

   // Monitor: every strobe must match the oldest expected event.
   always @(negedge clk) begin
      if (lfsr_latch) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL lfsr_latch unexpected digit=%h", lfsr_digit);
         end else begin
            e = q.pop_front();
            if (e.is_user || e.data != lfsr_digit) begin
               failures++;
               $display("FAIL lfsr_latch actual=%h expected=%h user_ev=%0b",
                        lfsr_digit, e.data, e.is_user);
            end
         end
      end
      if (user_latch) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL user_latch unexpected digit=%h cnt=%0d",
                     user_digit, digit_count);
         end else begin
            e = q.pop_front();
            if (!e.is_user || e.data[3:0] != user_digit ||
                e.cnt != digit_count) begin
               failures++;
               $display("FAIL user_latch actual=%h/%0d expected=%h/%0d",
                        user_digit, digit_count, e.data[3:0], e.cnt);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push_lfsr(input logic [15:0] v);
      q.push_back('{1'b0, v, 3'd0});
   endtask

   task automatic press(input logic [3:0] d, input bit acc);
      sw_digit_raw = d;
      @(posedge clk);
      #1 btn_enter_raw = 1'b1;
      if (acc) begin
         exp_cnt++;
         q.push_back('{1'b1, {12'h000, d}, 3'(exp_cnt)});
      end
      repeat (10) @(posedge clk);
      #1 btn_enter_raw = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   task automatic kick();
`ifdef GEN_BUTTON_EN
      btn_gen_raw = 1'b0;
      repeat (20) @(negedge clk);
      chk("gen_idle_step", 32'(lfsr_step), 0);
      chk("gen_idle_busy", 32'(busy), 0);
      btn_gen_raw = 1'b1;
`endif
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 120 && q.size() != 0; i++) @(negedge clk);
      chk("queue_drain", 32'(q.size()), 0);
      @(negedge clk);
   endtask

   function automatic logic [31:0] outs();
      return 32'({lfsr_step, lfsr_digit, lfsr_latch, user_digit,
                  user_latch, digit_count, lockout, busy});
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      btn_enter_raw = 1'b0;
      btn_gen_raw = 1'b0;
      sw_digit_raw = 4'h0;
      lfsr_value = 16'hA5C3;
      unlock = 1'b0;
      reset_sys = 1'b0;
      expired = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 0);

      push_lfsr(16'hA5C3);
      reset = 1'b1;
      kick();
      n = 0;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (lfsr_step) n++;
         if (lfsr_latch) begin
            seen = 1;
            break;
         end
      end
      chk("spin_len", n, 3);
      chk("first_latch_seen", 32'(seen), 1);
      @(negedge clk);
      chk("collect_busy", 32'(busy), 0);
      chk("collect_cnt0", 32'(digit_count), 0);

      sw_digit_raw = 4'h7;
      exp_cnt = 1;
      q.push_back('{1'b1, 16'h0007, 3'd1});
      @(posedge clk);
      #1 btn_enter_raw = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 n++;
         if (user_latch) break;
      end
      chk("press_latency", n, 7);
      chk("press_digit", 32'(user_digit), 7);
      chk("press_cnt", 32'(digit_count), 1);
      repeat (13) @(posedge clk);
      #1 btn_enter_raw = 1'b0;
      repeat (12) @(posedge clk);

      @(posedge clk);
      #1 btn_enter_raw = 1'b1;
      repeat (3) @(posedge clk);
      #1 btn_enter_raw = 1'b0;
      repeat (12) @(posedge clk);
      chk("glitch_cnt", 32'(digit_count), 1);
      chk("glitch_digit_hold", 32'(user_digit), 7);

      press(4'h2, 1);
      press(4'h3, 1);
      press(4'h4, 1);
      chk("wrong_cnt_clear", 32'(digit_count), 0);
      chk("wrong_busy", 32'(busy), 0);
      chk("wrong_lockout", 32'(lockout), 0);

      exp_cnt = 0;
      press(4'h1, 1);
      press(4'h2, 1);
      press(4'h3, 1);
      unlock = 1'b1;
      press(4'h4, 1);
      chk("done_busy", 32'(busy), 1);
      chk("done_cnt", 32'(digit_count), 4);
      chk("done_lockout", 32'(lockout), 0);
      chk("done_otp_hold", 32'(lfsr_digit), 32'hA5C3);

      lfsr_value = 16'h1234;
      push_lfsr(16'h1234);
      unlock = 1'b0;
      kick();
      wait_empty();
      chk("new_session_cnt", 32'(digit_count), 0);

      exp_cnt = 0;
      press(4'h9, 1);
      press(4'h8, 1);
      press(4'h7, 1);
      press(4'h6, 1);
      chk("retry_cnt_clear", 32'(digit_count), 0);
      exp_cnt = 0;
      press(4'h5, 1);
      chk("retry_accept", 32'(digit_count), 1);
      reset_sys = 1'b1;
      press(4'h6, 1);
      press(4'h7, 1);
      press(4'h8, 1);
      chk("lock_lockout", 32'(lockout), 1);
      chk("lock_busy", 32'(busy), 1);
      press(4'h9, 0);
      chk("lock_ignored_cnt", 32'(digit_count), 4);
      chk("lock_ignored_dig", 32'(user_digit), 8);

      lfsr_value = 16'hBEEF;
      push_lfsr(16'hBEEF);
      reset_sys = 1'b0;
      kick();
      wait_empty();
      chk("unlock_lockout", 32'(lockout), 0);
      chk("unlock_otp", 32'(lfsr_digit), 32'hBEEF);

      sw_digit_raw = 4'h3;
      @(posedge clk);
      #1 btn_enter_raw = 1'b1;
      repeat (6) @(posedge clk);
      #1 expired = 1'b1;
      @(posedge clk);
      #1;
      chk("expired_no_latch", 32'(user_latch), 0);
      chk("expired_lockout", 32'(lockout), 1);
      @(negedge clk);
      expired = 1'b0;
      btn_enter_raw = 1'b0;

      lfsr_value = 16'h0C0D;
      kick();
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (lfsr_step) begin
            seen = 1;
            break;
         end
      end
      chk("midspin_seen", 32'(seen), 1);
      reset = 1'b0;
      #1;
      chk("midspin_step", 32'(lfsr_step), 0);
      chk("midspin_latch", 32'(lfsr_latch), 0);
      repeat (4) @(negedge clk);
      chk("midspin_outputs", outs(), 0);

      push_lfsr(16'h0C0D);
      reset = 1'b1;
      kick();
      wait_empty();
      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/otp_input_sequencer.md
Name: otp_input_sequencer

Overview:
Front-end sequencer that drives the OTP checker FSM's input side. It steps the free-running LFSR and issues exactly one OTP capture per session. It turns raw pushbutton/switch input into single-cycle digit strobes. It blocks entry while the checker reports expiry or lockout, so the checker only sees clean, correctly ordered lfsr_latch/user_latch pulses.

Parameters:
DEBOUNCE_CYCLES, 500_000, consecutive stable cycles before a debounced level changes (10 ms at 50 MHz)
LFSR_SETTLE, 16, cycles lfsr_step is held high before the OTP is captured
CHECK_CYCLES, 4, cycles to wait after the 4th digit before sampling checker status
DIGITS, 4, digits per OTP entry (fixed at 4 to match 16-bit OTP)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_enter_raw  in  1  raw digit-enter pushbutton, asynchronous
btn_gen_raw  in  1  raw generate pushbutton, asynchronous (used only with GEN_BUTTON_EN)
sw_digit_raw  in  4  raw digit switches, asynchronous
lfsr_value  in  16  current LFSR state
unlock  in  1  checker: OTP matched
reset_sys  in  1  checker: attempts exhausted
expired  in  1  checker: entry window expired
lfsr_step  out  1  LFSR advance enable
lfsr_digit  out  16  captured OTP presented to checker
lfsr_latch  out  1  one-cycle OTP capture strobe
user_digit  out  4  latched user digit
user_latch  out  1  one-cycle digit strobe
digit_count  out  3  digits accepted this attempt, 0..4
lockout  out  1  high in S_LOCK
busy  out  1  high in every state except S_IDLE and S_COLLECT

Behaviour:
- Reset (async, active-low): all outputs 0; state S_IDLE; sync flops, debounce counters and debounced levels 0.
- Input conditioning: 2-FF synchronizer on every raw input. Debounced level follows the synchronized level after DEBOUNCE_CYCLES consecutive differing samples; counter clears on any agreeing sample. Press = rising edge of debounced level. Raw edge to user_latch = DEBOUNCE_CYCLES+3 clocks. Digit value is taken from the synchronized switches on the press cycle.
- FSM:
  - S_IDLE: go to S_SPIN next cycle.
  - S_SPIN: lfsr_step=1 for exactly LFSR_SETTLE cycles (counter width clog2(LFSR_SETTLE+1)), then go to S_ISSUE.
  - S_ISSUE: lfsr_digit<=lfsr_value; lfsr_latch=1 for one cycle; digit_count<=0; go to S_COLLECT.
  - S_COLLECT: each press drives user_digit<=digit and user_latch=1 for one cycle, then digit_count+1. When the DIGITS-th digit is latched, go to S_CHECK.
  - S_CHECK: wait CHECK_CYCLES, then sample status. unlock → S_DONE. reset_sys → S_LOCK. Otherwise → S_COLLECT with digit_count<=0 (wrong attempt).
  - S_DONE: hold until unlock=0, then S_IDLE.
  - S_LOCK: lockout=1; hold until reset_sys=0 and expired=0, then S_IDLE.
- expired=1 in S_COLLECT or S_CHECK → S_LOCK next cycle. expired wins over a simultaneous press: no user_latch.
- Presses outside S_COLLECT are dropped, not queued. Only one user_latch per press, however long the button is held.
- A button held through reset: debounced level rises DEBOUNCE_CYCLES+2 after reset release and counts as a press (accepted only in S_COLLECT).
- lfsr_digit holds its value until the next S_ISSUE. user_digit holds until the next press.
- Reset mid-session: immediate return to S_IDLE; no latch pulses emitted.

Optional Feature:
GEN_BUTTON_EN
- Defined: S_IDLE waits for a debounced btn_gen_raw press before entering S_SPIN; S_DONE and S_LOCK return to S_IDLE and wait again.
- Undefined: btn_gen_raw ignored, no debouncer instance for it; S_IDLE → S_SPIN unconditionally.

Decomposition:
- Package otp_seq_pkg: state encoding (S_IDLE..S_LOCK, 3 bits), DIGITS constant, default timing constants.
- Sub-module btn_debounce (sync + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES). Instantiated for btn_enter_raw and, if GEN_BUTTON_EN, btn_gen_raw.

Test Plan:
(DEBOUNCE_CYCLES=4, LFSR_SETTLE=3, CHECK_CYCLES=2)
- Reset release, lfsr_value=16'hA5C3 → lfsr_step high 3 cycles, then lfsr_latch single pulse with lfsr_digit=16'hA5C3; all outputs 0 during reset.
- In S_COLLECT, sw=4'h7, button pressed and held 20 cycles → exactly one user_latch, 7 cycles after the raw edge, user_digit=4'h7, digit_count=1. A 3-cycle glitch press → no latch.
- Four presses 1,2,3,4, unlock=1 two cycles after the 4th → digit_count=4, S_DONE, busy=1. unlock=0 → S_IDLE, new lfsr_latch.
- Four presses, unlock=0 and reset_sys=0 at sample → digit_count returns to 0, further presses accepted. Then reset_sys=1 at the next check → lockout=1, presses ignored until reset_sys=0.
- expired rises on the same cycle as a debounced press in S_COLLECT → no user_latch, lockout=1 next cycle.
- Reset asserted in the middle of S_SPIN → lfsr_step=0 immediately, no lfsr_latch. With GEN_BUTTON_EN, after reset nothing happens until a btn_gen press.
